mul_issue_ctrl: RTL and testbench
=================================

Name: mul_issue_ctrl

Overview:
- Upstream sequencer for the multiply unit (mu); sits between decode/execute and mu.
- Accepts RV32M multiply ops (MUL/MULH/MULHSU/MULHU), latches operands and destination, and fires a one-cycle enable into mu.
- Stalls the pipeline until mu reports valid, then presents a one-cycle writeback with rd.
- Handles flush of an in-flight op and a watchdog timeout.

Parameters:
- XLEN, 32, operand/result width; must match mu.
- TIMEOUT, 64, max cycles in WAIT before error abort.
- CNT_W, 7, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- issue_valid  in  1  decode presents a candidate op this cycle.
- funct3  in  3  RV32M funct3; only 3'b0xx accepted.
- rs1_val  in  XLEN  operand a.
- rs2_val  in  XLEN  operand b.
- rd  in  5  destination register.
- flush  in  1  pipeline kill of any in-flight op.
- mu_en  out  1  one-cycle start pulse to mu.
- mu_a  out  XLEN  latched operand a to mu.
- mu_b  out  XLEN  latched operand b to mu.
- mu_mulctl  out  2  op select to mu, equal to latched funct3[1:0].
- mu_res  in  XLEN  mu result.
- mu_valid  in  1  mu result valid (single-cycle pulse).
- stall  out  1  hold upstream pipeline.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_rd  out  5  writeback destination.
- wb_data  out  XLEN  writeback data.
- err  out  1  sticky timeout flag; cleared by next accepted issue.

Behaviour:
- Reset: state=IDLE; all outputs 0 (mu_en, mu_a, mu_b, mu_mulctl, stall, wb_valid, wb_rd, wb_data, err); counter 0.
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE: accept when issue_valid=1, funct3[2]=0, and flush=0. Latch rs1_val, rs2_val, funct3[1:0], rd; go to ISSUE; stall=1 from the next cycle. funct3[2]=1 is ignored and stays IDLE.
- ISSUE: mu_en=1 for exactly this one cycle; mu_a, mu_b, mu_mulctl hold latched values; go to WAIT; counter cleared.
- WAIT:
  - mu_valid=1: wb_data<=mu_res, wb_rd<=latched rd, wb_valid=1 for the next cycle only; stall drops that same cycle; go to IDLE.
  - Otherwise counter increments. At counter==TIMEOUT: err<=1, no wb_valid, go to IDLE.
- Latency: accept at cycle N, mu_en at N+1, wb_valid one cycle after the mu_valid edge.
- mu_a, mu_b, mu_mulctl stay stable from ISSUE until the next accept.
- issue_valid while stall=1: ignored; upstream must hold.
- flush:
  - In ISSUE or WAIT: go to DRAIN (mu cannot abort). stall stays 1; mu_valid in DRAIN is discarded, then go to IDLE. Timeout also applies in DRAIN, without setting err.
  - flush and mu_valid in the same WAIT cycle: flush wins; result dropped; go to IDLE.
  - flush in IDLE: no effect, and it blocks acceptance that cycle.
- wb_valid never asserts twice per accepted op.
- Async rst mid-op forces IDLE immediately. A later stray mu_valid in IDLE is ignored.

Optional Feature:
- Macro MUL_ISSUE_CACHE_EN.
- Defined: keep the last completed {a, b, mulctl, result}. An accepted op with identical {a, b, mulctl} skips mu: no mu_en, no stall, wb_valid on the cycle after accept with the cached data. The cache is invalidated on rst, flush, and timeout.
- Undefined: every accepted op goes through mu. No cache registers are present.

Test Plan:
- MUL rs1=-3, rs2=-4, rd=5; mu returns after 3 cycles -> one mu_en with mulctl=00, wb_valid once, wb_rd=5, wb_data=12; stall high from N+1 until the wb cycle.
- MULH/MULHU/MULHSU with -3, -4 -> mulctl 01/11/10; wb_data 0x00000000 / 0xFFFFFFF9 / 0xFFFFFFFD.
- MUL 16*48 issued while stall=1 from a prior op -> ignored; re-presented after wb -> wb_data=768.
- Flush during WAIT, mu_valid two cycles later -> no wb_valid; stall stays high until mu_valid, then IDLE; next MUL 2*3 -> 6.
- mu never answers -> err=1 at TIMEOUT=64 cycles after ISSUE, stall drops, no wb_valid; next accept clears err.
- Cache build: MUL -3, -4 twice -> second op shows no mu_en and wb_valid=12 at N+1; flush, then repeat -> mu_en is seen again.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: sequencer between decode/execute and the multiply unit (mu).
// Accepts RV32M multiply ops (funct3 = 3'b0xx), latches the operands and the destination,
// fires a one-cycle start pulse into mu, stalls upstream until mu answers, then
// presents a one-cycle writeback. It also handles flush of an in-flight op and
// aborts on a watchdog timeout.
//
// Optional feature: define MUL_ISSUE_CACHE_EN to keep the last completed
// {a, b, mulctl, result}. An identical op is then answered from that cache
// without involving mu.
module mul_issue_ctrl #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd,
    input  logic            flush,
    output logic            mu_en,
    output logic [XLEN-1:0] mu_a,
    output logic [XLEN-1:0] mu_b,
    output logic [1:0]      mu_mulctl,
    input  logic [XLEN-1:0] mu_res,
    input  logic            mu_valid,
    output logic            stall,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            err
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDrain
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [1:0]      ctl_q, ctl_d;
    logic [4:0]      rd_q, rd_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            accept;
    logic            cnt_expired;
    logic            op_done;     // mu result written back this cycle
    logic            op_expired;  // watchdog abort from WAIT this cycle
    logic            cache_hit;
    logic [XLEN-1:0] hit_data;

    // Only IDLE accepts. A flush in the same cycle kills the candidate op.
    assign accept = (state_q == StIdle) & issue_valid & ~funct3[2] & ~flush;

    // The counter holds the number of WAIT/DRAIN cycles already spent. The
    // TIMEOUT-th cycle without an answer is the last one before the abort.
    assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef MUL_ISSUE_CACHE_EN
    logic            cache_vld_q, cache_vld_d;
    logic [XLEN-1:0] cache_a_q, cache_a_d;
    logic [XLEN-1:0] cache_b_q, cache_b_d;
    logic [1:0]      cache_ctl_q, cache_ctl_d;
    logic [XLEN-1:0] cache_res_q, cache_res_d;

    assign cache_hit = cache_vld_q & (cache_a_q == rs1_val) & (cache_b_q == rs2_val)
                     & (cache_ctl_q == funct3[1:0]);
    assign hit_data  = cache_res_q;

    // Cache next state: fill on a real mu completion, drop on flush or abort.
    always_comb begin
        cache_vld_d = cache_vld_q;
        cache_a_d   = cache_a_q;
        cache_b_d   = cache_b_q;
        cache_ctl_d = cache_ctl_q;
        cache_res_d = cache_res_q;
        if (flush || op_expired) begin
            cache_vld_d = 1'b0;
        end else if (op_done) begin
            cache_vld_d = 1'b1;
            cache_a_d   = a_q;
            cache_b_d   = b_q;
            cache_ctl_d = ctl_q;
            cache_res_d = mu_res;
        end
    end

    // Cache registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_vld_q <= 1'b0;
            cache_a_q   <= '0;
            cache_b_q   <= '0;
            cache_ctl_q <= 2'b00;
            cache_res_q <= '0;
        end else begin
            cache_vld_q <= cache_vld_d;
            cache_a_q   <= cache_a_d;
            cache_b_q   <= cache_b_d;
            cache_ctl_q <= cache_ctl_d;
            cache_res_q <= cache_res_d;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_data  = '0;
`endif

    // Next-state, operand latch, writeback and watchdog logic.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        ctl_d      = ctl_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        op_done    = 1'b0;
        op_expired = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d   = rs1_val;
                    b_d   = rs2_val;
                    ctl_d = funct3[1:0];
                    rd_d  = rd;
                    err_d = 1'b0;
                    if (cache_hit) begin
                        // Answered locally: no mu start, no stall.
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd;
                        wb_data_d  = hit_data;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end

            StIssue: begin
                cnt_d = '0;
                // mu has already been started; a flush can only wait for it.
                state_d = flush ? StDrain : StWait;
            end

            StWait: begin
                if (flush) begin
                    if (mu_valid || cnt_expired) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StDrain;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end else if (mu_valid) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = mu_res;
                    op_done    = 1'b1;
                    state_d    = StIdle;
                end else if (cnt_expired) begin
                    err_d      = 1'b1;
                    op_expired = 1'b1;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StDrain: begin
                // Swallow the result of the killed op; no error on expiry.
                if (mu_valid || cnt_expired) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            ctl_q      <= 2'b00;
            rd_q       <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ctl_q      <= ctl_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs are decoded from registered state only.
    assign mu_en     = (state_q == StIssue);
    assign stall     = (state_q != StIdle);
    assign mu_a      = a_q;
    assign mu_b      = b_q;
    assign mu_mulctl = ctl_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl. A behavioural multiply unit answers mu_en after a chosen
// delay. It computes the product from the operands the DUT presents. Expected writebacks
// come from the vector table and the sequences below. They are queued at issue time and
// popped when wb_valid appears. Inputs change and outputs are sampled on the falling edge.
module tb_mul_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic        flush;
    logic        mu_en;
    logic [31:0] mu_a;
    logic [31:0] mu_b;
    logic [1:0]  mu_mulctl;
    logic [31:0] mu_res;
    logic        mu_valid;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;

`ifdef MUL_ISSUE_CACHE_EN
    localparam bit CacheOn = 1'b1;
`else
    localparam bit CacheOn = 1'b0;
`endif

    always #5 clk = ~clk;

    mul_issue_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .funct3     (funct3),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .rd         (rd),
        .flush      (flush),
        .mu_en      (mu_en),
        .mu_a       (mu_a),
        .mu_b       (mu_b),
        .mu_mulctl  (mu_mulctl),
        .mu_res     (mu_res),
        .mu_valid   (mu_valid),
        .stall      (stall),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .err        (err)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dst;
        int          dly;
        logic [31:0] exp;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[4];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          wb_cnt = 0;
    int          mu_en_cnt = 0;
    int          mu_cd = 0;
    int          mu_delay = 3;
    bit          mu_auto = 1'b1;
    logic [31:0] mu_pend = '0;

    function automatic logic [31:0] ref_mul(logic [1:0] ctl, logic [31:0] a, logic [31:0] b);
        logic [63:0] ae;
        logic [63:0] be;
        logic [63:0] p;
        ae = (ctl == 2'b01 || ctl == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        be = (ctl == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ae * be;
        return (ctl == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One cycle: sample outputs at the falling edge, run scoreboard and mu model.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (wb_valid) begin
            wb_cnt++;
            if (sb_q.size() == 0) begin
                chk("wb_unexpected", 32'(wb_valid), 0);
            end else begin
                e = sb_q.pop_front();
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_data", wb_data, e.data);
            end
        end
        if (mu_en) mu_en_cnt++;
        mu_valid = 1'b0;
        mu_res   = $urandom;
        if (mu_cd > 0) begin
            mu_cd--;
            if (mu_cd == 0) begin
                mu_valid = 1'b1;
                mu_res   = mu_pend;
            end
        end
        if (mu_en && mu_auto) begin
            mu_cd   = mu_delay;
            mu_pend = ref_mul(mu_mulctl, mu_a, mu_b);
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (stall && g < 200) begin
            cyc();
            g++;
        end
        chk("idle_before_issue", 32'(stall), 0);
    endtask

    task automatic drive(logic [2:0] f3, logic [31:0] a, logic [31:0] b, logic [4:0] dst);
        issue_valid = 1'b1;
        funct3      = f3;
        rs1_val     = a;
        rs2_val     = b;
        rd          = dst;
    endtask

    task automatic undrive();
        issue_valid = 1'b0;
        funct3      = 3'($urandom);
        rs1_val     = $urandom;
        rs2_val     = $urandom;
        rd          = 5'($urandom);
    endtask

    // Full transaction: accept, mu round trip (or cache hit), single writeback.
    task automatic run_op(logic [2:0] f3, logic [31:0] a, logic [31:0] b, logic [4:0] dst,
                          int dly, logic [31:0] exp, bit use_mu);
        int wb0;
        int mu0;
        int lat;
        bit bad_stall;
        wait_idle();
        wb0      = wb_cnt;
        mu0      = mu_en_cnt;
        mu_delay = dly;
        drive(f3, a, b, dst);
        sb_q.push_back('{rd: dst, data: exp});
        cyc();
        undrive();
        chk("err_clear_on_accept", 32'(err), 0);
        if (use_mu) begin
            chk("mu_en", 32'(mu_en), 1);
            chk("stall_issue", 32'(stall), 1);
            chk("mulctl", 32'(mu_mulctl), 32'(f3[1:0]));
            chk("mu_a", mu_a, a);
            chk("mu_b", mu_b, b);
            lat       = 0;
            bad_stall = 1'b0;
            while (!wb_valid && lat < 300) begin
                cyc();
                lat++;
                if (!wb_valid && !stall) bad_stall = 1'b1;
            end
            chk("wb_latency", lat, dly + 1);
            chk("stall_held", 32'(bad_stall), 0);
            chk("stall_at_wb", 32'(stall), 0);
            chk("mu_a_stable", mu_a, a);
        end else begin
            chk("hit_mu_en", 32'(mu_en), 0);
            chk("hit_stall", 32'(stall), 0);
            chk("hit_wb_valid", 32'(wb_valid), 1);
        end
        repeat (3) cyc();
        chk("wb_count", wb_cnt - wb0, 1);
        chk("mu_en_count", mu_en_cnt - mu0, use_mu ? 1 : 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int wb0;
        int mu0;
        int lat;
        bit bad;

        rst = 1'b1;
        flush = 1'b0;
        mu_valid = 1'b0;
        mu_res = '0;
        undrive();

        vecs[0] = '{3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5'd5, 3, 32'd12};
        vecs[1] = '{3'b001, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5'd6, 2, 32'h0000_0000};
        vecs[2] = '{3'b011, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5'd7, 4, 32'hFFFF_FFF9};
        vecs[3] = '{3'b010, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5'd8, 1, 32'hFFFF_FFFD};

        // Reset state.
        cyc();
        cyc();
        chk("rst_mu_en", 32'(mu_en), 0);
        chk("rst_mu_a", mu_a, 0);
        chk("rst_mu_b", mu_b, 0);
        chk("rst_mulctl", 32'(mu_mulctl), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_rd", 32'(wb_rd), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        cyc();

        // MUL / MULH / MULHU / MULHSU with -3, -4.
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].dst, vecs[i].dly, vecs[i].exp,
                   1'b1);
        end

        // An op presented while stalled is ignored; it is re-presented afterwards.
        wait_idle();
        wb0 = wb_cnt;
        mu0 = mu_en_cnt;
        mu_delay = 5;
        drive(3'b000, 32'd5, 32'd7, 5'd3);
        sb_q.push_back('{rd: 5'd3, data: 32'd35});
        cyc();
        drive(3'b000, 32'd16, 32'd48, 5'd9);
        repeat (3) cyc();
        undrive();
        lat = 0;
        while (!wb_valid && lat < 100) begin
            cyc();
            lat++;
        end
        chk("stalled_issue_mu_a", mu_a, 32'd5);
        repeat (2) cyc();
        chk("stalled_issue_wb_count", wb_cnt - wb0, 1);
        chk("stalled_issue_mu_en_count", mu_en_cnt - mu0, 1);
        run_op(3'b000, 32'd16, 32'd48, 5'd9, 2, 32'd768, 1'b1);

        // funct3[2]=1 is not a multiply: ignored.
        wait_idle();
        wb0 = wb_cnt;
        mu0 = mu_en_cnt;
        drive(3'b101, 32'd2, 32'd3, 5'd1);
        cyc();
        undrive();
        chk("div_ignored_stall", 32'(stall), 0);
        repeat (2) cyc();
        chk("div_ignored_mu_en", mu_en_cnt - mu0, 0);
        chk("div_ignored_wb", wb_cnt - wb0, 0);

        // Flush in IDLE blocks acceptance.
        drive(3'b000, 32'd1, 32'd1, 5'd1);
        flush = 1'b1;
        cyc();
        undrive();
        flush = 1'b0;
        chk("flush_idle_stall", 32'(stall), 0);
        repeat (2) cyc();
        chk("flush_idle_mu_en", mu_en_cnt - mu0, 0);
        chk("flush_idle_wb", wb_cnt - wb0, 0);

        // Flush during WAIT; mu answers two cycles later into DRAIN.
        mu_delay = 4;
        drive(3'b000, 32'd9, 32'd9, 5'd2);
        cyc();
        undrive();
        chk("flush_wait_mu_en", 32'(mu_en), 1);
        cyc();
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("drain_stall", 32'(stall), 1);
        cyc();
        chk("drain_stall_at_valid", 32'(stall), 1);
        cyc();
        chk("drain_exit_stall", 32'(stall), 0);
        repeat (2) cyc();
        chk("drain_no_wb", wb_cnt - wb0, 0);
        run_op(3'b000, 32'd2, 32'd3, 5'd10, 2, 32'd6, 1'b1);

        // Flush and mu_valid in the same WAIT cycle: flush wins.
        wait_idle();
        wb0 = wb_cnt;
        mu_delay = 3;
        drive(3'b000, 32'd4, 32'd5, 5'd11);
        cyc();
        undrive();
        cyc();
        cyc();
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_valid_idle", 32'(stall), 0);
        repeat (2) cyc();
        chk("flush_valid_no_wb", wb_cnt - wb0, 0);

        // mu never answers: watchdog abort.
        wait_idle();
        wb0 = wb_cnt;
        mu_auto = 1'b0;
        drive(3'b000, 32'd11, 32'd13, 5'd12);
        cyc();
        undrive();
        chk("timeout_mu_en", 32'(mu_en), 1);
        bad = 1'b0;
        for (int k = 0; k < 64; k++) begin
            cyc();
            if (!stall || err || wb_valid) bad = 1'b1;
        end
        chk("timeout_wait_window", 32'(bad), 0);
        cyc();
        chk("timeout_err", 32'(err), 1);
        chk("timeout_stall", 32'(stall), 0);
        chk("timeout_wb", 32'(wb_valid), 0);
        repeat (3) cyc();
        chk("err_sticky", 32'(err), 1);
        chk("timeout_no_wb", wb_cnt - wb0, 0);
        mu_auto = 1'b1;
        run_op(3'b000, 32'd7, 32'd6, 5'd13, 3, 32'd42, 1'b1);

        // Async reset mid-op; the late mu_valid lands in IDLE and is ignored.
        wait_idle();
        wb0 = wb_cnt;
        mu_delay = 6;
        drive(3'b000, 32'd8, 32'd8, 5'd4);
        cyc();
        undrive();
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("async_rst_stall", 32'(stall), 0);
        chk("async_rst_mu_a", mu_a, 0);
        chk("async_rst_mulctl", 32'(mu_mulctl), 0);
        cyc();
        rst = 1'b0;
        repeat (6) cyc();
        chk("stray_valid_no_wb", wb_cnt - wb0, 0);
        chk("stray_valid_stall", 32'(stall), 0);

        // Repeated op: served from cache when the feature is built in.
        run_op(3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5'd5, 3, 32'd12, 1'b1);
        run_op(3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5'd6, 3, 32'd12, !CacheOn);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        run_op(3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5'd7, 3, 32'd12, 1'b1);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
